// File: rtl/cpu_debug_ocimem_ctrl_if.sv
// CPU-side bus into the on-chip debug RAM controller.
// cpu_byteenable exists only when OCIMEM_CPU_BYTEEN_EN is defined.
interface cpu_debug_ocimem_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_waitrequest;
`ifdef OCIMEM_CPU_BYTEEN_EN
    logic [3:0]        cpu_byteenable;
`endif

    modport master (
        output cpu_addr,
        output cpu_read,
        output cpu_write,
        output cpu_wdata,
`ifdef OCIMEM_CPU_BYTEEN_EN
        output cpu_byteenable,
`endif
        input  cpu_rdata,
        input  cpu_waitrequest
    );

    modport slave (
        input  cpu_addr,
        input  cpu_read,
        input  cpu_write,
        input  cpu_wdata,
`ifdef OCIMEM_CPU_BYTEEN_EN
        input  cpu_byteenable,
`endif
        output cpu_rdata,
        output cpu_waitrequest
    );
endinterface

// File: rtl/cpu_debug_ocimem_ctrl.sv
// Debug RAM controller: JTAG strobes vs CPU accesses on one RAM port.
// Optional macro OCIMEM_CPU_BYTEEN_EN adds CPU byte-enable writes.
module cpu_debug_ocimem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [37:0]           jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_no_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    cpu_debug_ocimem_ctrl_if.slave cpu,
    output logic [31:0]           MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);

    typedef enum logic [2:0] {
        IDLE, DBG_RD, DBG_RD_WAIT, DBG_WR, CPU_RD
    } state_t;

    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W-1:0] mon_a, mon_a_n;
    logic [31:0]       mon_d_n, wr_data, wr_data_n;
    logic              rdy_n, err_n;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       ram_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic              ram_re, ram_we;
    logic              stall;

    logic [15:0] raw;
    logic        any_strobe;
    logic        unused;

    assign raw        = jdo[17:2];
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a
                      | take_action_ocimem_b;
    assign unused     = ^{jdo[37:36], jdo[34:32]} ^ ^jdo[1:0]
                      ^ ^jdo[34:18];

    always_comb begin
        state_n   = state;
        mon_a_n   = mon_a;
        mon_d_n   = MonDReg;
        rdy_n     = monitor_ready;
        err_n     = monitor_error;
        wr_data_n = wr_data;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = mon_a;
        ram_wdata = wr_data;
        ram_be    = 4'hf;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                stall = any_strobe ? (cpu.cpu_read | cpu.cpu_write)
                                   : cpu.cpu_read;
                if (take_action_ocimem_a) begin
                    if (raw >= DEPTH16) begin
                        err_n = 1'b1;
                        rdy_n = 1'b1;
                    end else begin
                        mon_a_n = raw[ADDR_W-1:0];
                        err_n   = 1'b0;
                        if (jdo[35]) begin
                            rdy_n   = 1'b0;
                            state_n = DBG_RD;
                        end else begin
                            rdy_n = 1'b1;
                        end
                    end
                end else if (take_no_action_ocimem_a) begin
                    mon_a_n = mon_a + 1'b1;
                    rdy_n   = 1'b0;
                    state_n = DBG_RD;
                end else if (take_action_ocimem_b) begin
                    // latch data so DBG_WR does not depend on jdo
                    wr_data_n = jdo[31:0];
                    rdy_n     = 1'b0;
                    state_n   = DBG_WR;
                end else if (cpu.cpu_write) begin
                    ram_we    = 1'b1;
                    ram_addr  = cpu.cpu_addr;
                    ram_wdata = cpu.cpu_wdata;
`ifdef OCIMEM_CPU_BYTEEN_EN
                    ram_be    = cpu.cpu_byteenable;
`endif
                end else if (cpu.cpu_read) begin
                    ram_re   = 1'b1;
                    ram_addr = cpu.cpu_addr;
                    state_n  = CPU_RD;
                end
            end
            DBG_RD: begin
                stall   = 1'b1;
                ram_re  = 1'b1;
                state_n = DBG_RD_WAIT;
            end
            DBG_RD_WAIT: begin
                stall   = 1'b1;
                mon_d_n = ram_q;
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            DBG_WR: begin
                stall   = 1'b1;
                ram_we  = 1'b1;
                mon_d_n = wr_data;
                mon_a_n = mon_a + 1'b1;
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            CPU_RD: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a         <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
            wr_data       <= '0;
        end else begin
            state         <= state_n;
            mon_a         <= mon_a_n;
            MonDReg       <= mon_d_n;
            monitor_ready <= rdy_n;
            monitor_error <= err_n;
            wr_data       <= wr_data_n;
        end
    end

    // RAM contents survive reset; writes are blocked while it is held
    always_ff @(posedge clk) begin
        if (ram_we && reset_n) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_addr];
    end

    assign cpu.cpu_waitrequest = stall & reset_n;
    assign cpu.cpu_rdata       = (state == CPU_RD) ? ram_q : '0;

endmodule

// File: doc/cpu_debug_ocimem_ctrl.md
Name: cpu_debug_ocimem_ctrl

Overview:
Sysclk-domain consumer of the debug-slave strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and of the 38-bit jdo word.
- Executes JTAG-initiated read/write accesses into the CPU's on-chip debug RAM.
- Arbitrates those accesses against CPU-side accesses to the same RAM.
- Returns MonDReg, monitor_ready and monitor_error to the debug-slave tck logic.

Parameters:
DEPTH, 256, number of 32-bit words in the debug RAM (power of two, 16..4096)
ADDR_W, 8, log2(DEPTH); width of the internal word address

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data word, stable while any strobe is high
take_action_ocimem_a  in  1  one-cycle strobe: load address and optionally start a read
take_no_action_ocimem_a  in  1  one-cycle strobe: read at the next address
take_action_ocimem_b  in  1  one-cycle strobe: write jdo[31:0] at the current address
cpu_addr  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request, held until waitrequest is low
cpu_write  in  1  CPU write request, held until waitrequest is low
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  CPU read data, valid when cpu_read=1 and cpu_waitrequest=0
cpu_waitrequest  out  1  CPU stall
MonDReg  out  32  debug data register
monitor_ready  out  1  debug operation complete
monitor_error  out  1  last debug operation addressed out of range

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=0, monitor_error=0, cpu_rdata=0, cpu_waitrequest=0. RAM contents are not cleared.
- RAM: single port, synchronous read with 1-cycle latency. Only one access per cycle, debug or CPU.
- States: IDLE, DBG_RD, DBG_RD_WAIT, DBG_WR, CPU_RD.
- take_action_ocimem_a:
  - Raw address is jdo[17:2] (16 bits).
  - If raw >= DEPTH: monitor_error=1, monitor_ready=1, no access, state stays IDLE.
  - Otherwise: MonAReg=raw[ADDR_W-1:0] and monitor_error=0.
  - If jdo[35]=1, clear monitor_ready and go to DBG_RD. Otherwise set monitor_ready=1.
- take_no_action_ocimem_a: MonAReg=MonAReg+1 (wraps DEPTH-1 -> 0, no error), monitor_ready=0, go to DBG_RD.
- take_action_ocimem_b: monitor_ready=0, go to DBG_WR.
- DBG_RD: drive RAM read at MonAReg, then go to DBG_RD_WAIT.
- DBG_RD_WAIT: MonDReg=RAM output, monitor_ready=1, go to IDLE.
  - Debug read latency: strobe to monitor_ready = 3 clk edges.
- DBG_WR: write jdo[31:0] at MonAReg, MonDReg=jdo[31:0], MonAReg=MonAReg+1 (wrapping), monitor_ready=1, go to IDLE.
  - Debug write latency: 2 edges.
- Strobe rules:
  - Strobes are mutually exclusive; if two are asserted together, priority is a > no_action_a > b.
  - A strobe arriving outside IDLE is dropped. This cannot occur in normal use, because JTAG spacing is much larger than 3 cycles.
- CPU side:
  - In IDLE with no strobe, cpu_write completes in the same cycle (cpu_waitrequest=0).
  - In IDLE with no strobe, cpu_read enters CPU_RD with cpu_waitrequest=1. CPU_RD presents cpu_rdata with cpu_waitrequest=0 for one cycle, then returns to IDLE.
  - Debug strobe in the same cycle as a CPU request: debug wins, cpu_waitrequest=1 until the debug operation returns to IDLE.
  - cpu_waitrequest=1 whenever state is in DBG_*.
- Same-address hazard: a debug write followed immediately by a CPU read of the same word returns the new data.
- Reset mid-operation: immediate return to IDLE with reset values. Any pending CPU request restarts after reset.

Optional Feature:
Macro: OCIMEM_CPU_BYTEEN_EN.
- Defined: adds input cpu_byteenable[3:0]. CPU writes update only the enabled bytes; byteenable=0000 is a completed no-op write. Debug writes are always full-word.
- Undefined: no port; all CPU writes are full-word.

Test Plan:
- Debug write/read: take_action_ocimem_a with jdo[17:2]=5, jdo[35]=0, then take_action_ocimem_b with jdo[31:0]=0xDEADBEEF -> monitor_ready=1 two edges later. Then take_action_ocimem_a with address 5, jdo[35]=1 -> MonDReg=0xDEADBEEF and monitor_ready=1 three edges after the strobe.
- Auto-increment and wrap: write 0x11 at DEPTH-1 -> MonAReg=0. take_no_action_ocimem_a -> MonDReg = word 1, since the next read address is 1. Separately, load address DEPTH-1 and read, then no_action -> reads word 0, monitor_error=0.
- Out of range: jdo[17:2]=DEPTH -> monitor_error=1, monitor_ready=1 the next cycle, RAM unchanged, MonAReg unchanged.
- Arbitration: cpu_read at address 3 asserted in the same cycle as take_action_ocimem_b -> cpu_waitrequest=1 for the debug write plus one CPU_RD cycle, then cpu_rdata = new value if the debug address was 3.
- CPU path: cpu_write 0xCAFE0001 at address 7 -> completes in 1 cycle. cpu_read at address 7 -> waitrequest 1 then 0, cpu_rdata=0xCAFE0001. With OCIMEM_CPU_BYTEEN_EN, byteenable=0010 writing 0x0000AB00 -> read back 0xCAFEAB01.
- Reset mid-read: assert reset_n=0 during DBG_RD_WAIT -> outputs return to reset values immediately. After release, a read at address 5 still returns 0xDEADBEEF.
